// File: rtl/maj_tt_pkg.sv
// Shared constants and state encoding for the majority-network truth-table sweeper.
package maj_tt_pkg;

   localparam int N_IN  = 7;
   localparam int TT_W  = 2 ** N_IN;
   localparam int CNT_W = N_IN + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SWEEP = ST_SWEEP,
      DONE  = ST_DONE
   } state_e;

endpackage

// File: rtl/maj_tt_hold_ctr.sv
// Settle/hold counter: holds each vector SETTLE_CYCLES extra cycles, then
// asserts cap_stb for exactly one cycle so the top captures f_in.
module maj_tt_hold_ctr #(
   parameter int unsigned SETTLE_CYCLES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic cap_stb
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

   logic [3:0] hold_q;
   logic [3:0] hold_d;

   // Count while enabled; restart at zero on capture or whenever disabled.
   always_comb begin
      cap_stb = en && (hold_q == SETTLE_LAST);
      hold_d  = 4'd0;
      if (en && !cap_stb) begin
         hold_d = hold_q + 4'd1;
      end
   end

   // Hold counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 4'd0;
      end else begin
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/maj_tt_sweeper.sv
// Truth-table sweeper: drives all TT_W patterns into a function-under-test,
// captures its output into tt and counts the onset.
// Optional self-check against an expected table: define MAJ_TT_CHECK_EN.
//
// Result handshake: tt/onset_cnt are valid while tt_valid=1 and stay stable
// until the cycle in which tt_valid & tt_ready are both high (transfer edge);
// tt_valid drops on the following cycle. abort beats the transfer.
module maj_tt_sweeper
   import maj_tt_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic [N_IN-1:0]  x,
   input  logic             f_in,
   output logic [TT_W-1:0]  tt,
   output logic [CNT_W-1:0] onset_cnt,
   output logic             tt_valid,
   input  logic             tt_ready,
`ifdef MAJ_TT_CHECK_EN
   input  logic [TT_W-1:0]  exp_tt,
   output logic             match,
   output logic [CNT_W-1:0] mismatch_cnt,
`endif
   output logic [1:0]       dbg_state
);

   localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);

   state_e             state_q, state_d;
   logic [N_IN-1:0]    idx_q, idx_d;
   logic [TT_W-1:0]    tt_q, tt_d;
   logic [CNT_W-1:0]   onset_q, onset_d;
   logic               hold_en;
   logic               cap_stb;

`ifdef MAJ_TT_CHECK_EN
   logic [TT_W-1:0]    exp_q, exp_d;
   logic [CNT_W-1:0]   mism_q, mism_d;
`endif

   // Hold counter runs only while sweeping; abort zeroes it immediately.
   assign hold_en = (state_q == SWEEP) && !abort;

   maj_tt_hold_ctr #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_hold_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (hold_en),
      .cap_stb (cap_stb)
   );

   // Sweep FSM: start acceptance, per-vector capture, result handoff, abort.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tt_d    = tt_q;
      onset_d = onset_q;
`ifdef MAJ_TT_CHECK_EN
      exp_d   = exp_q;
      mism_d  = mism_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SWEEP;
               idx_d   = '0;
               tt_d    = '0;
               onset_d = '0;
`ifdef MAJ_TT_CHECK_EN
               exp_d   = exp_tt;
               mism_d  = '0;
`endif
            end
         end
         SWEEP: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (cap_stb) begin
               tt_d[idx_q] = f_in;
               onset_d     = onset_q + CNT_W'(f_in);
`ifdef MAJ_TT_CHECK_EN
               mism_d      = mism_q + CNT_W'(f_in != exp_q[idx_q]);
`endif
               // Last increment wraps idx back to 0, leaving x at 0 in DONE.
               idx_d = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (abort || tt_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tt_q    <= '0;
         onset_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tt_q    <= tt_d;
         onset_q <= onset_d;
      end
   end

`ifdef MAJ_TT_CHECK_EN
   // Expected-table snapshot and mismatch counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q  <= '0;
         mism_q <= '0;
      end else begin
         exp_q  <= exp_d;
         mism_q <= mism_d;
      end
   end

   assign match        = (mism_q == '0);
   assign mismatch_cnt = mism_q;
`endif

   assign x         = idx_q;
   assign tt        = tt_q;
   assign onset_cnt = onset_q;
   assign tt_valid  = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_maj_tt_sweeper.sv
// Directed bench for maj_tt_sweeper: two instances (SETTLE_CYCLES 0 and 2),
// bench-side FUT models, hand-computed expected tables.
`timescale 1ns/1ps
module tb_maj_tt_sweeper;
   import maj_tt_pkg::*;

   localparam logic [TT_W-1:0] MAJ_TT  = {16{8'hE8}};
   localparam logic [TT_W-1:0] ONES_TT = {TT_W{1'b1}};
   localparam logic [TT_W-1:0] X6_TT   = {{64{1'b1}}, {64{1'b0}}};
   localparam logic [TT_W-1:0] PART_TT = TT_W'(48'hE8E8E8E8E8E8);

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- DUT 1: combinational FUT, SETTLE_CYCLES=0 ----------------
   logic             start    = 1'b0;
   logic             abort    = 1'b0;
   logic             tt_ready = 1'b0;
   logic             f_in;
   logic             busy;
   logic [N_IN-1:0]  x;
   logic [TT_W-1:0]  tt;
   logic [CNT_W-1:0] onset_cnt;
   logic             tt_valid;
   logic [1:0]       dbg_state;
   int               fut_mode = 2;   // 0: tied 0, 1: tied 1, 2: maj(x0,x1,x2)

   assign f_in = (fut_mode == 0) ? 1'b0 :
                 (fut_mode == 1) ? 1'b1 :
                 ((x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]));

`ifdef MAJ_TT_CHECK_EN
   logic [TT_W-1:0]  exp_tt = '0;
   logic             match;
   logic [CNT_W-1:0] mismatch_cnt;
   logic             match2;
   logic [CNT_W-1:0] mismatch_cnt2;
`endif

   maj_tt_sweeper #(.SETTLE_CYCLES(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .busy         (busy),
      .x            (x),
      .f_in         (f_in),
      .tt           (tt),
      .onset_cnt    (onset_cnt),
      .tt_valid     (tt_valid),
      .tt_ready     (tt_ready),
`ifdef MAJ_TT_CHECK_EN
      .exp_tt       (exp_tt),
      .match        (match),
      .mismatch_cnt (mismatch_cnt),
`endif
      .dbg_state    (dbg_state)
   );

   // ---------------- DUT 2: FUT = x6 through 2-stage pipe, SETTLE_CYCLES=2 ----------------
   logic             start2 = 1'b0;
   logic             busy2;
   logic [N_IN-1:0]  x2;
   logic [TT_W-1:0]  tt2;
   logic [CNT_W-1:0] onset_cnt2;
   logic             tt_valid2;
   logic [1:0]       dbg_state2;
   logic             p1, p2;

   // Two-stage pipelined FUT model.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= 1'b0;
         p2 <= 1'b0;
      end else begin
         p1 <= x2[6];
         p2 <= p1;
      end
   end

   maj_tt_sweeper #(.SETTLE_CYCLES(2)) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start2),
      .abort        (1'b0),
      .busy         (busy2),
      .x            (x2),
      .f_in         (p2),
      .tt           (tt2),
      .onset_cnt    (onset_cnt2),
      .tt_valid     (tt_valid2),
      .tt_ready     (1'b1),
`ifdef MAJ_TT_CHECK_EN
      .exp_tt       ({TT_W{1'b0}}),
      .match        (match2),
      .mismatch_cnt (mismatch_cnt2),
`endif
      .dbg_state    (dbg_state2)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [TT_W-1:0] got, input logic [TT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Pulse start on DUT 1 and wait (bounded) for tt_valid; tracks x stepping.
   task automatic run_sweep(output int cyc, output int x_bad);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc   = 0;
      x_bad = 0;
      while (!tt_valid && cyc < 2000) begin
         if (x !== N_IN'(cyc)) x_bad++;
         @(negedge clk);
         cyc++;
      end
   endtask

   // One-cycle ready pulse; result must be released on the next cycle.
   task automatic accept();
      @(negedge clk) tt_ready = 1'b1;
      @(negedge clk) tt_ready = 1'b0;
      check("valid_drop", TT_W'(tt_valid), TT_W'(1'b0));
      check("idle_after_ack", TT_W'(dbg_state), TT_W'(ST_IDLE));
   endtask

   task automatic wait_x50(output int cyc);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      while (x !== 7'd50 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_x50", TT_W'(x), TT_W'(7'd50));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int x_bad;
      int bad;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_x", TT_W'(x), '0);
      check("rst_tt", tt, '0);
      check("rst_onset", TT_W'(onset_cnt), '0);
      check("rst_valid", TT_W'(tt_valid), '0);
      check("rst_busy", TT_W'(busy), '0);
      check("rst_state", TT_W'(dbg_state), TT_W'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // Majority FUT, full sweep
      fut_mode = 2;
`ifdef MAJ_TT_CHECK_EN
      exp_tt = MAJ_TT;
`endif
      run_sweep(cyc, x_bad);
      check("maj_latency", TT_W'(cyc), TT_W'(128));
      check("maj_x_step", TT_W'(x_bad), '0);
      check("maj_tt", tt, MAJ_TT);
      check("maj_onset", TT_W'(onset_cnt), TT_W'(64));
      check("maj_busy_done", TT_W'(busy), TT_W'(1'b1));
`ifdef MAJ_TT_CHECK_EN
      check("chk_match", TT_W'(match), TT_W'(1'b1));
      check("chk_mism", TT_W'(mismatch_cnt), '0);
`endif

      // Back-pressure in DONE with a start pulse that must be ignored
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) start = 1'b1;
         if (i == 4) start = 1'b0;
         @(negedge clk);
         if (tt_valid !== 1'b1 || tt !== MAJ_TT || onset_cnt !== 8'd64) bad++;
      end
      check("hold_in_done", TT_W'(bad), '0);
      accept();
      check("idle_busy", TT_W'(busy), '0);

      // Tied 1, then tied 0
      fut_mode = 1;
      run_sweep(cyc, x_bad);
      check("ones_latency", TT_W'(cyc), TT_W'(128));
      check("ones_x_step", TT_W'(x_bad), '0);
      check("ones_tt", tt, ONES_TT);
      check("ones_onset", TT_W'(onset_cnt), TT_W'(128));
      accept();
      fut_mode = 0;
      run_sweep(cyc, x_bad);
      check("zeros_latency", TT_W'(cyc), TT_W'(128));
      check("zeros_tt", tt, '0);
      check("zeros_onset", TT_W'(onset_cnt), '0);
      accept();

      // Pipelined FUT on DUT 2: each x held 3 cycles
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      cyc   = 0;
      x_bad = 0;
      while (!tt_valid2 && cyc < 2000) begin
         if (x2 !== N_IN'(cyc / 3)) x_bad++;
         @(negedge clk);
         cyc++;
      end
      check("pipe_latency", TT_W'(cyc), TT_W'(384));
      check("pipe_x_hold", TT_W'(x_bad), '0);
      check("pipe_tt", tt2, X6_TT);
      check("pipe_onset", TT_W'(onset_cnt2), TT_W'(64));
      @(negedge clk);
      check("pipe_release", TT_W'(busy2), '0);
      check("pipe_state", TT_W'(dbg_state2), TT_W'(ST_IDLE));

      // Abort at x=50: idx 50 must not be captured
      fut_mode = 2;
      wait_x50(cyc);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort_state", TT_W'(dbg_state), TT_W'(ST_IDLE));
      check("abort_x", TT_W'(x), '0);
      check("abort_busy", TT_W'(busy), '0);
      check("abort_partial_tt", tt, PART_TT);
      check("abort_partial_onset", TT_W'(onset_cnt), TT_W'(24));
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (tt_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      check("abort_no_valid", TT_W'(bad), '0);

      // Fresh full sweep after abort
      run_sweep(cyc, x_bad);
      check("reabort_latency", TT_W'(cyc), TT_W'(128));
      check("reabort_tt", tt, MAJ_TT);
      check("reabort_onset", TT_W'(onset_cnt), TT_W'(64));
      accept();

      // Async reset at x=50
      wait_x50(cyc);
      rst_n = 1'b0;
      #1;
      check("arst_x", TT_W'(x), '0);
      check("arst_tt", tt, '0);
      check("arst_onset", TT_W'(onset_cnt), '0);
      check("arst_valid", TT_W'(tt_valid), '0);
      check("arst_busy", TT_W'(busy), '0);
      @(negedge clk) rst_n = 1'b1;

      // abort wins over start in IDLE
      @(negedge clk) begin
         start = 1'b1;
         abort = 1'b1;
      end
      @(negedge clk) begin
         start = 1'b0;
         abort = 1'b0;
      end
      check("abort_beats_start", TT_W'(dbg_state), TT_W'(ST_IDLE));
      check("abort_beats_start_busy", TT_W'(busy), '0);

`ifdef MAJ_TT_CHECK_EN
      // Expected table with bit 0 wrong: exactly one mismatch
      exp_tt = MAJ_TT | TT_W'(1);
      run_sweep(cyc, x_bad);
      check("chk_bad_match", TT_W'(match), '0);
      check("chk_bad_mism", TT_W'(mismatch_cnt), TT_W'(1));
      accept();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
